// File: rtl/data_proc_pkg.sv
// Shared constants, FSM state type and lane arithmetic for the data_proc chain.
// Defining DATA_PROC2_SAT_EN turns the lane increment into a saturating add.
package data_proc_pkg;
  localparam int DATA_W    = 512;
  localparam int LANE_W    = 32;
  localparam int NUM_LANES = DATA_W / LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [DATA_W-1:0] lane_inc(input logic [DATA_W-1:0] data,
                                                 input logic [LANE_W-1:0] inc);
    logic [DATA_W-1:0] res;
`ifdef DATA_PROC2_SAT_EN
    logic [LANE_W:0] sum;
`endif
    res = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
`ifdef DATA_PROC2_SAT_EN
      sum = {1'b0, data[i*LANE_W +: LANE_W]} + {1'b0, inc};
      res[i*LANE_W +: LANE_W] = sum[LANE_W] ? {LANE_W{1'b1}} : sum[LANE_W-1:0];
`else
      res[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W] + inc;
`endif
    end
    return res;
  endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream buffer (output register + skid register) with a registered
// input ready, so upstream ready never depends combinationally on downstream ready.
module axis_skid_buffer #(
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              allow,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  logic [DATA_W-1:0] out_data_r, out_data_s, skid_data_r, skid_data_s;
  logic              out_valid_r, out_valid_s, skid_valid_r, skid_valid_s;
  logic              in_ready_r, in_ready_s, in_hs_s, out_hs_s;

  // Next-state of both entries; ready only re-opens once the skid slot is free.
  always_comb begin
    in_hs_s      = in_valid && in_ready_r;
    out_hs_s     = out_valid_r && out_ready;
    out_data_s   = out_data_r;
    out_valid_s  = out_valid_r;
    skid_data_s  = skid_data_r;
    skid_valid_s = skid_valid_r;
    if (out_hs_s) begin
      out_data_s   = skid_valid_r ? skid_data_r : out_data_r;
      out_valid_s  = skid_valid_r;
      skid_valid_s = 1'b0;
    end else begin
      out_valid_s  = out_valid_r;
    end
    if (in_hs_s) begin
      if (out_valid_s) begin
        skid_data_s  = in_data;
        skid_valid_s = 1'b1;
      end else begin
        out_data_s   = in_data;
        out_valid_s  = 1'b1;
      end
    end else begin
      skid_data_s = skid_data_r;
    end
    in_ready_s = allow && !skid_valid_s;
  end

  // Buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_r   <= {DATA_W{1'b0}};
      out_valid_r  <= 1'b0;
      skid_data_r  <= {DATA_W{1'b0}};
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
    end else begin
      out_data_r   <= out_data_s;
      out_valid_r  <= out_valid_s;
      skid_data_r  <= skid_data_s;
      skid_valid_r <= skid_valid_s;
      in_ready_r   <= in_ready_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
endmodule

// File: rtl/data_proc2.sv
// data_proc2: adds INC to every lane of each beat, ap_ctrl_hs controlled.
// Build option DATA_PROC2_SAT_EN: saturating lanes instead of modular wrap.
module data_proc2 import data_proc_pkg::*; #(
  parameter int unsigned INC   = 1,
  parameter int          CNT_W = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [CNT_W-1:0]  beat_count,
  input  logic [DATA_W-1:0] Input_1_TDATA,
  input  logic              Input_1_TVALID,
  output logic              Input_1_TREADY,
  output logic [DATA_W-1:0] Output_1_TDATA,
  output logic              Output_1_TVALID,
  input  logic              Output_1_TREADY
);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LANE_W-1:0] INC_LANE = INC[LANE_W-1:0];

  state_e            state_r, state_s;
  logic [CNT_W-1:0]  n_r, n_s, in_cnt_r, in_cnt_s, out_cnt_r, out_cnt_s;
  logic              in_hs_s, out_hs_s, allow_s, ap_done_r, ap_idle_r;
  logic [DATA_W-1:0] inc_data_s;

  assign in_hs_s    = Input_1_TVALID && Input_1_TREADY;
  assign out_hs_s   = Output_1_TVALID && Output_1_TREADY;
  assign inc_data_s = lane_inc(Input_1_TDATA, INC_LANE);

  // FSM next state and beat counters; RUN ends when the n-th beat leaves.
  always_comb begin
    state_s   = state_r;
    n_s       = n_r;
    in_cnt_s  = in_cnt_r;
    out_cnt_s = out_cnt_r;
    case (state_r)
      IDLE: begin
        if (ap_start) begin
          state_s   = RUN;
          n_s       = beat_count;
          in_cnt_s  = CNT_ZERO;
          out_cnt_s = CNT_ZERO;
        end else begin
          state_s   = IDLE;
        end
      end
      RUN: begin
        if (in_hs_s) begin
          in_cnt_s = in_cnt_r + CNT_ONE;
        end else begin
          in_cnt_s = in_cnt_r;
        end
        if (out_hs_s) begin
          out_cnt_s = out_cnt_r + CNT_ONE;
        end else begin
          out_cnt_s = out_cnt_r;
        end
        if (out_cnt_s == n_r) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    allow_s = (state_s == RUN) && (in_cnt_s < n_s);
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_r   <= IDLE;
      n_r       <= CNT_ZERO;
      in_cnt_r  <= CNT_ZERO;
      out_cnt_r <= CNT_ZERO;
      ap_done_r <= 1'b0;
      ap_idle_r <= 1'b1;
    end else begin
      state_r   <= state_s;
      n_r       <= n_s;
      in_cnt_r  <= in_cnt_s;
      out_cnt_r <= out_cnt_s;
      ap_done_r <= (state_s == DONE);
      ap_idle_r <= (state_s == IDLE);
    end
  end

  assign ap_done  = ap_done_r;
  assign ap_ready = ap_done_r;
  assign ap_idle  = ap_idle_r;

  axis_skid_buffer #(.DATA_W(DATA_W)) u_skid (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .allow     (allow_s),
    .in_data   (inc_data_s),
    .in_valid  (Input_1_TVALID),
    .in_ready  (Input_1_TREADY),
    .out_data  (Output_1_TDATA),
    .out_valid (Output_1_TVALID),
    .out_ready (Output_1_TREADY)
  );
endmodule

// File: tb/tb_data_proc2.sv
// Directed bench for data_proc2: basic, wrap, backpressure, zero count, overrun, reset.
// Expected lanes follow DATA_PROC2_SAT_EN in the same way as the design build.
module tb_data_proc2;
  logic         ap_clk = 1'b0;
  logic         ap_rst_n, ap_start, ap_done, ap_idle, ap_ready;
  logic [31:0]  beat_count;
  logic [511:0] Input_1_TDATA, Output_1_TDATA;
  logic         Input_1_TVALID, Input_1_TREADY, Output_1_TVALID, Output_1_TREADY;

  always #5 ap_clk = ~ap_clk;

  data_proc2 dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .beat_count(beat_count),
    .Input_1_TDATA(Input_1_TDATA), .Input_1_TVALID(Input_1_TVALID),
    .Input_1_TREADY(Input_1_TREADY), .Output_1_TDATA(Output_1_TDATA),
    .Output_1_TVALID(Output_1_TVALID), .Output_1_TREADY(Output_1_TREADY)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  logic [511:0] src_q[$];
  int           src_seq  = 0;
  int           chk_seq  = 0;
  int           acc_tot  = 0;
  int           emit_tot = 0;
  logic [511:0] last_out;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] model(input logic [511:0] d);
    logic [511:0] r;
    logic [31:0]  l;
    r = {512{1'b0}};
    for (int i = 0; i < 16; i++) begin
      l = d[i*32 +: 32];
`ifdef DATA_PROC2_SAT_EN
      r[i*32 +: 32] = (l == 32'hFFFF_FFFF) ? l : l + 32'd1;
`else
      r[i*32 +: 32] = l + 32'd1;
`endif
    end
    return r;
  endfunction

  task automatic drive_src();
    if (src_seq < src_q.size()) begin
      Input_1_TVALID = 1'b1;
      Input_1_TDATA  = src_q[src_seq];
    end else begin
      Input_1_TVALID = 1'b0;
      Input_1_TDATA  = {512{1'b0}};
    end
  endtask

  // One cycle of traffic: record handshakes that the coming edge will complete.
  task automatic traffic(input string tag, input bit rnd, inout int acc, inout int emit);
    logic [511:0] e;
    Output_1_TREADY = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    drive_src();
    if (Input_1_TVALID && Input_1_TREADY) begin
      src_seq++; acc++; acc_tot++;
    end
    if (Output_1_TVALID && Output_1_TREADY) begin
      e = {512{1'bx}};
      if (chk_seq < src_q.size()) e = model(src_q[chk_seq]);
      chk({tag, "_data"}, Output_1_TDATA, e);
      last_out = Output_1_TDATA;
      chk_seq++; emit++; emit_tot++;
    end
  endtask

  task automatic run_inv(input string tag, input int n, input bit rnd);
    int acc, emit, last_c, done_c;
    bit tready_seen, pv, pr;
    logic [511:0] pd;
    acc = 0; emit = 0; last_c = -1; done_c = -1;
    tready_seen = 1'b0; pv = 1'b0; pr = 1'b0; pd = {512{1'b0}};
    beat_count = n; ap_start = 1'b1; Output_1_TREADY = 1'b1;
    drive_src();
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (ap_done) begin
        done_c = c;
        break;
      end
      if (pv && !pr) begin
        chk({tag, "_stall_valid"}, Output_1_TVALID, 1'b1);
        chk({tag, "_stall_data"}, Output_1_TDATA, pd);
      end
      chk({tag, "_occupancy"}, (acc_tot - emit_tot) <= 2, 1'b1);
      if (Input_1_TREADY) tready_seen = 1'b1;
      traffic(tag, rnd, acc, emit);
      if (Output_1_TVALID && Output_1_TREADY) last_c = c;
      pv = Output_1_TVALID; pr = Output_1_TREADY; pd = Output_1_TDATA;
      @(posedge ap_clk); #1;
    end
    chk({tag, "_done_seen"}, done_c >= 0, 1'b1);
    chk({tag, "_ready_pulse"}, ap_ready, 1'b1);
    chk({tag, "_accepted"}, acc, n);
    chk({tag, "_emitted"}, emit, n);
    chk({tag, "_done_latency"}, done_c, (n == 0) ? 1 : last_c + 1);
    if (n == 0) chk({tag, "_tready_never"}, tready_seen, 1'b0);
    @(posedge ap_clk); #1;
    chk({tag, "_done_one_cycle"}, ap_done, 1'b0);
    chk({tag, "_idle_back"}, ap_idle, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ap_done"}, ap_done, 1'b0);
    chk({tag, "_ap_ready"}, ap_ready, 1'b0);
    chk({tag, "_ap_idle"}, ap_idle, 1'b1);
    chk({tag, "_in_tready"}, Input_1_TREADY, 1'b0);
    chk({tag, "_out_tvalid"}, Output_1_TVALID, 1'b0);
    chk({tag, "_out_tdata"}, Output_1_TDATA, {512{1'b0}});
  endtask

  initial begin
    logic [511:0] b, basic_exp, wrap_exp;
    int acc, emit;
    ap_rst_n = 1'b0; ap_start = 1'b0; beat_count = 32'd0;
    Input_1_TDATA = {512{1'b0}}; Input_1_TVALID = 1'b0; Output_1_TREADY = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    chk_reset_outputs("reset");
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Basic: four beats of lanes 0..15 must come out as 1..16.
    for (int i = 0; i < 16; i++) begin
      b[i*32 +: 32] = i;
      basic_exp[i*32 +: 32] = i + 1;
    end
    repeat (4) src_q.push_back(b);
    run_inv("basic", 4, 1'b0);
    chk("basic_const", last_out, basic_exp);

    // Wrap: a mixed beat, then an all-ones beat whose result is hand-known.
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = (i % 2 == 0) ? 32'hFFFF_FFFE : 32'h7FFF_FFFF;
    src_q.push_back(b);
    src_q.push_back({16{32'hFFFF_FFFF}});
`ifdef DATA_PROC2_SAT_EN
    wrap_exp = {16{32'hFFFF_FFFF}};
`else
    wrap_exp = {512{1'b0}};
`endif
    run_inv("wrap", 2, 1'b0);
    chk("wrap_const", last_out, wrap_exp);

    // Backpressure: 16 distinct random beats with a 50% downstream ready.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom();
      src_q.push_back(b);
    end
    run_inv("bp", 16, 1'b1);

    // Zero count with one beat already pending; it must stay pending.
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = 32'h1000 + i;
    src_q.push_back(b);
    run_inv("zero", 0, 1'b0);
    chk("zero_pending", src_q.size() - src_seq, 1);

    // Overrun: five beats offered, three taken, the other two by the next call.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) b[i*32 +: 32] = 32'h2000 + k * 16 + i;
      src_q.push_back(b);
    end
    run_inv("overrun", 3, 1'b0);
    chk("overrun_pending", src_q.size() - src_seq, 2);
    run_inv("overrun_next", 2, 1'b0);
    chk("overrun_drained", src_q.size() - src_seq, 0);

    // Reset after three accepted beats of an eight-beat invocation.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 16; i++) b[i*32 +: 32] = 32'h3000 + k * 16 + i;
      src_q.push_back(b);
    end
    acc = 0; emit = 0;
    beat_count = 32'd8; ap_start = 1'b1; Output_1_TREADY = 1'b1;
    drive_src();
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    for (int c = 0; c < 50 && acc < 3; c++) begin
      traffic("rst_pre", 1'b0, acc, emit);
      @(posedge ap_clk); #1;
    end
    chk("rst_pre_accepted", acc, 3);
    ap_rst_n = 1'b0;
    while (src_q.size() > src_seq) void'(src_q.pop_back());
    drive_src();
    @(posedge ap_clk); #1;
    chk_reset_outputs("rst_mid");
    chk_seq = src_seq;
    emit_tot = acc_tot;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk("rst_no_done", ap_done, 1'b0);
    chk("rst_idle", ap_idle, 1'b1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) b[i*32 +: 32] = 32'h4000 + k * 16 + i;
      src_q.push_back(b);
    end
    run_inv("rst_after", 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
